piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
Parallel-in, serial-out transmitter. It is the sending end of the registered bit chain used elsewhere in the design, where a serial input ripples through successive flops one stage per clock. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clock, with a frame strobe and an end-of-word pulse. It feeds a downstream serial-in shift chain or receiver.

Parameters:
WIDTH, 8, word width in bits; legal range 2..32.
LSB_FIRST, 0, bit order: 0 sends data_in[WIDTH-1] first, 1 sends data_in[0] first.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  synchronous, active-high reset.
load_valid  input  1  upstream has a word on data_in.
load_ready  output  1  block can accept a word this cycle.
data_in  input  WIDTH  parallel word; sampled only on accept.
ser_out  output  1  serial data bit, registered.
ser_frame  output  1  high while ser_out carries a valid bit.
word_done  output  1  one-cycle pulse with the last bit of each word.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high (reset).
- Reset values: state=IDLE, shift register=0, bit counter=0, ser_out=0, ser_frame=0, word_done=0.
- Reset has priority over all other inputs.
- Reset mid-word aborts the word with no further bits. Outputs take their reset values after the reset edge.
- State machine: IDLE and SHIFT.
  - IDLE: ser_frame=0 and ser_out=0.
  - IDLE to SHIFT on an accept.
  - SHIFT to SHIFT on the last bit when a back-to-back accept occurs.
  - SHIFT to IDLE on the last bit when no accept occurs.
- Accept: load_valid && load_ready at a rising edge.
- load_ready is 1 in IDLE, and 1 in SHIFT only when the bit counter is WIDTH-1. It is 0 in all other SHIFT cycles.
- load_ready is derived from registered state only. It must not depend on load_valid in the same cycle.
- Latency: for an accept at edge k, the first bit appears on ser_out after edge k. Bit i appears after edge k+i, for i=0..WIDTH-1.
- ser_frame is high for exactly WIDTH consecutive cycles per word.
- Back-to-back words: an accept during the last-bit cycle loads the new word at that same edge. The first bit of the new word follows immediately, with no gap cycle and ser_frame staying high.
- word_done is high during the cycle ser_out presents bit WIDTH-1 of a word. It is never high in IDLE.
- Bit counter:
  - width is clog2(WIDTH).
  - cleared to 0 on accept.
  - increments once per SHIFT cycle.
  - never exceeds WIDTH-1 and never wraps silently.
- Shift register:
  - loads data_in on accept.
  - shifts toward the output end each SHIFT cycle, filling with 0.
  - ser_out is its registered output-end bit.
- load_valid while load_ready=0: ignored. data_in is not sampled, and upstream must hold the word.
- data_in changes after an accept have no effect on the word in flight.

Test Plan:
- Reset: assert reset 2 cycles with load_valid=1 and data_in=0xFF -> ser_out=0, ser_frame=0, word_done=0, load_ready=1 the cycle after reset deasserts.
- MSB-first single word: WIDTH=8, LSB_FIRST=0, accept 0x0F -> ser_out=0,0,0,0,1,1,1,1 over 8 cycles; ser_frame high for exactly those 8; word_done high only on the 8th; then IDLE with load_ready=1.
- LSB-first: LSB_FIRST=1, accept 0x0F -> ser_out=1,1,1,1,0,0,0,0; word_done on the 8th bit.
- Back-to-back: load_valid held with 0xA5 then 0x3C -> second accept occurs in the last-bit cycle; ser_frame high 16 contiguous cycles; ser_out=1010010100111100; word_done pulses on cycles 8 and 16.
- Stall: load_valid=1 during bits 0..6 of a word -> load_ready=0 and the word is not accepted; accepted only at bit 7.
- Reset mid-word: reset asserted after bit 3 of 0xFF -> next cycle ser_frame=0, ser_out=0, load_ready=1; a new accept of 0x81 yields 1,0,0,0,0,0,0,1.

Source files
------------

// File: rtl/piso_serializer_if.sv
// Handshake and serial-output bundle for piso_serializer.
// The master drives words in, and the slave (the serializer) drives the serial side.
interface piso_serializer_if #(
    parameter int WIDTH = 8
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] data_in;
    logic             ser_out;
    logic             ser_frame;
    logic             word_done;

    modport master (
        output load_valid, data_in,
        input  load_ready, ser_out, ser_frame, word_done
    );

    modport slave (
        input  load_valid, data_in,
        output load_ready, ser_out, ser_frame, word_done
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: accepts a WIDTH-bit word on a valid/ready handshake
// and sends it one bit per clock, with a frame strobe and an end-of-word pulse.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input logic                clk,
    input logic                reset,
    piso_serializer_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_frame_q, ser_frame_d;
    logic             word_done_q, word_done_d;
    logic             last_bit;
    logic             load_ready;
    logic             accept;

    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
        if (LSB_FIRST) return {1'b0, v[WIDTH-1:1]};
        else           return {v[WIDTH-2:0], 1'b0};
    endfunction

    function automatic logic out_bit(input logic [WIDTH-1:0] v);
        return LSB_FIRST ? v[0] : v[WIDTH-1];
    endfunction

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        last_bit    = (state_q == SHIFT) && (cnt_q == LAST);
        load_ready  = (state_q == IDLE) || last_bit;
        accept      = bus.load_valid && load_ready;

        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        ser_out_d   = 1'b0;
        ser_frame_d = 1'b0;
        word_done_d = 1'b0;

        if (accept) begin
            // A load during the last-bit cycle chains straight into the next word.
            state_d     = SHIFT;
            cnt_d       = '0;
            shreg_d     = bus.data_in;
            ser_out_d   = out_bit(bus.data_in);
            ser_frame_d = 1'b1;
        end else if (state_q == SHIFT) begin
            shreg_d = shift_once(shreg_q);
            if (last_bit) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d       = cnt_q + 1'b1;
                ser_out_d   = out_bit(shreg_d);
                ser_frame_d = 1'b1;
                word_done_d = (cnt_d == LAST);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            ser_out_q   <= 1'b0;
            ser_frame_q <= 1'b0;
            word_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            ser_out_q   <= ser_out_d;
            ser_frame_q <= ser_frame_d;
            word_done_q <= word_done_d;
        end
    end

    assign bus.load_ready = load_ready;
    assign bus.ser_out    = ser_out_q;
    assign bus.ser_frame  = ser_frame_q;
    assign bus.word_done  = word_done_q;
endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an MSB-first and an LSB-first instance, with a per-instance
// scoreboard of expected serial bits that is filled on each accept and drained one bit per cycle.
module tb_piso_serializer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic mon_en = 1'b0;
    int   n_checks = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    piso_serializer_if #(.WIDTH(8)) m_if ();
    piso_serializer_if #(.WIDTH(8)) l_if ();

    piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_msb (.clk(clk), .reset(reset), .bus(m_if.slave));
    piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_lsb (.clk(clk), .reset(reset), .bus(l_if.slave));

    typedef struct {
        logic b;
        logic done;
    } sb_t;

    // Each vector gives the expected serial stream with the first bit sent as bit 7.
    typedef struct {
        logic       lsb;
        logic [7:0] word;
        logic [7:0] exp;
    } vec_t;

    sb_t        q_m[$];
    sb_t        q_l[$];
    sb_t        e_m, e_l;
    logic [7:0] exp_m, exp_l;

    task automatic check(input string name, input logic act, input logic req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("msb_ready", m_if.load_ready, q_m.size() <= 1);
            if (q_m.size() > 0) begin
                e_m = q_m.pop_front();
                check("msb_ser_out", m_if.ser_out, e_m.b);
                check("msb_word_done", m_if.word_done, e_m.done);
                check("msb_frame", m_if.ser_frame, 1'b1);
            end else begin
                check("msb_idle_out", m_if.ser_out, 1'b0);
                check("msb_idle_done", m_if.word_done, 1'b0);
                check("msb_idle_frame", m_if.ser_frame, 1'b0);
            end
            if (reset) q_m.delete();
            else if (m_if.load_valid && m_if.load_ready)
                for (int i = 0; i < 8; i++) q_m.push_back('{b: exp_m[7-i], done: (i == 7)});
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("lsb_ready", l_if.load_ready, q_l.size() <= 1);
            if (q_l.size() > 0) begin
                e_l = q_l.pop_front();
                check("lsb_ser_out", l_if.ser_out, e_l.b);
                check("lsb_word_done", l_if.word_done, e_l.done);
                check("lsb_frame", l_if.ser_frame, 1'b1);
            end else begin
                check("lsb_idle_out", l_if.ser_out, 1'b0);
                check("lsb_idle_done", l_if.word_done, 1'b0);
                check("lsb_idle_frame", l_if.ser_frame, 1'b0);
            end
            if (reset) q_l.delete();
            else if (l_if.load_valid && l_if.load_ready)
                for (int i = 0; i < 8; i++) q_l.push_back('{b: exp_l[7-i], done: (i == 7)});
        end
    end

    // Offers a word and returns #1 after the accepting edge; afterwards data_in is
    // scrambled to show that the word in flight is unaffected.
    task automatic send(input logic sel, input logic [7:0] word, input logic [7:0] exp, input logic hold);
        logic accepted;
        accepted = 1'b0;
        if (sel) begin
            l_if.load_valid = 1'b1; l_if.data_in = word; exp_l = exp;
        end else begin
            m_if.load_valid = 1'b1; m_if.data_in = word; exp_m = exp;
        end
        for (int c = 0; c < 40 && !accepted; c++) begin
            @(negedge clk);
            accepted = sel ? l_if.load_ready : m_if.load_ready;
        end
        check("accept_within_budget", accepted, 1'b1);
        @(posedge clk);
        #1;
        if (sel) begin
            l_if.data_in = ~word;
            if (!hold) l_if.load_valid = 1'b0;
        end else begin
            m_if.data_in = ~word;
            if (!hold) m_if.load_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        logic idle;
        idle = 1'b0;
        for (int c = 0; c < 60 && !idle; c++) begin
            @(posedge clk);
            idle = (q_m.size() == 0) && (q_l.size() == 0);
        end
        check("drain_within_budget", idle, 1'b1);
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{lsb: 1'b0, word: 8'h0F, exp: 8'b0000_1111};
        vecs[1] = '{lsb: 1'b1, word: 8'h0F, exp: 8'b1111_0000};
        vecs[2] = '{lsb: 1'b0, word: 8'hA5, exp: 8'b1010_0101};
        vecs[3] = '{lsb: 1'b1, word: 8'h01, exp: 8'b1000_0000};
        vecs[4] = '{lsb: 1'b0, word: 8'h80, exp: 8'b1000_0000};
        vecs[5] = '{lsb: 1'b1, word: 8'hC8, exp: 8'b0001_0011};
        vecs[6] = '{lsb: 1'b0, word: 8'h01, exp: 8'b0000_0001};
        vecs[7] = '{lsb: 1'b1, word: 8'h80, exp: 8'b0000_0001};

        // Reset held two cycles with a pending word that must not be taken.
        m_if.load_valid = 1'b1; m_if.data_in = 8'hFF; exp_m = 8'hFF;
        l_if.load_valid = 1'b1; l_if.data_in = 8'hFF; exp_l = 8'hFF;
        @(posedge clk);
        #1 mon_en = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_if.load_valid = 1'b0;
        l_if.load_valid = 1'b0;
        @(negedge clk);
        check("ready_after_reset", m_if.load_ready, 1'b1);
        check("frame_after_reset", m_if.ser_frame, 1'b0);
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            send(vecs[i].lsb, vecs[i].word, vecs[i].exp, 1'b0);
            wait_idle();
        end

        // Back-to-back: valid held across two words, 16 contiguous frame cycles.
        send(1'b0, 8'hA5, 8'hA5, 1'b1);
        send(1'b0, 8'h3C, 8'h3C, 1'b0);
        wait_idle();

        // Stall: next word offered during bits 0..6 of the current one.
        send(1'b1, 8'h55, 8'hAA, 1'b0);
        send(1'b1, 8'h96, 8'h69, 1'b0);
        wait_idle();

        // Reset after bit 3 of 0xFF, then a fresh word.
        send(1'b0, 8'hFF, 8'hFF, 1'b0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("ready_after_abort", m_if.load_ready, 1'b1);
        check("frame_after_abort", m_if.ser_frame, 1'b0);
        check("out_after_abort", m_if.ser_out, 1'b0);
        @(posedge clk);
        #1;
        send(1'b0, 8'h81, 8'h81, 1'b0);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
